design_1_wrapper: RTL and testbench

DESIGN_1_WRAPPER -- requirements
Module: design_1_wrapper

---
 rtl/design_1_wrapper_pkg.sv | 15 +
 rtl/design_1_wrapper_para2serial.sv | 49 ++++
 rtl/design_1_wrapper.sv | 56 +++++
 tb/tb_design_1_wrapper.sv | 117 +++++++++++
 4 files changed

// File: rtl/design_1_wrapper_pkg.sv
// Shared widths and constants for the sawtooth tone generator and its codec serializer.
package design_1_wrapper_pkg;

  localparam int PHASE_W    = 32;
  localparam int SAMPLE_W   = 16;
  localparam int FRAME_BITS = 32;
  localparam int FREQ_W     = 15;
  // round(2^32 / 96000): one Hz of tone per frame-rate phase step
  localparam int INC_SCALE  = 44739;
  localparam int AMP_SHIFT  = 2;

  typedef logic [PHASE_W-1:0]         phase_t;
  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/design_1_wrapper_para2serial.sv
// Codec-side serializer: edge-detects bclk/pblrc and shifts {sample, sample} out MSB first.
module para2serial
  import design_1_wrapper_pkg::*;
(
  input  logic    clk96M,
  input  logic    reset,
  input  logic    bclk_i,
  input  logic    pblrc_i,
  input  sample_t sample_i,
  output logic    lrc_rise_o,
  output logic    pbdat_o
);

  logic                  bclk_d_q;
  logic                  pblrc_d_q;
  logic                  bclk_fall;
  logic                  lrc_fall;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] shift_d;

  assign bclk_fall  = bclk_d_q & ~bclk_i;
  assign lrc_rise_o = ~pblrc_d_q & pblrc_i;
  assign lrc_fall   = pblrc_d_q & ~pblrc_i;

  // Frame load wins over a coincident bit shift so bit 31 is never skipped.
  always_comb begin
    shift_d = shift_q;
    if (lrc_fall) begin
      shift_d = {sample_i, sample_i};
    end else if (bclk_fall) begin
      shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk96M) begin
    if (reset) begin
      bclk_d_q  <= 1'b0;
      pblrc_d_q <= 1'b0;
      shift_q   <= '0;
    end else begin
      bclk_d_q  <= bclk_i;
      pblrc_d_q <= pblrc_i;
      shift_q   <= shift_d;
    end
  end

  assign pbdat_o = shift_q[FRAME_BITS-1];

endmodule

// File: rtl/design_1_wrapper.sv
// Sawtooth tone generator: phase accumulator stepped once per frame, sample sent to the codec serializer.
module design_1_wrapper
  import design_1_wrapper_pkg::*;
(
  input  logic              clk96M,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq,
  input  logic              bclk,
  input  logic              pblrc,
  output logic              pbdat
);

  logic        lrc_rise;
  logic [30:0] inc31;
  phase_t      inc;
  phase_t      phase_sum;
  phase_t      phase_q;
  phase_t      phase_d;
  sample_t     sample_q;
  sample_t     sample_d;

  // freq * INC_SCALE never exceeds 31 bits for a 15-bit freq.
  assign inc31     = 31'(freq) * 31'(INC_SCALE);
  assign inc       = {1'b0, inc31};
  assign phase_sum = phase_q + inc;

  always_comb begin
    phase_d  = phase_q;
    sample_d = sample_q;
    if (lrc_rise) begin
      phase_d  = phase_sum;
      sample_d = $signed(phase_sum[PHASE_W-1 -: SAMPLE_W]) >>> AMP_SHIFT;
    end
  end

  always_ff @(posedge clk96M) begin
    if (reset) begin
      phase_q  <= '0;
      sample_q <= '0;
    end else begin
      phase_q  <= phase_d;
      sample_q <= sample_d;
    end
  end

  para2serial u_para2serial (
    .clk96M     (clk96M),
    .reset      (reset),
    .bclk_i     (bclk),
    .pblrc_i    (pblrc),
    .sample_i   (sample_q),
    .lrc_rise_o (lrc_rise),
    .pbdat_o    (pbdat)
  );

endmodule

// File: tb/tb_design_1_wrapper.sv
// Frame-level bench: drives bclk/pblrc like the codec and deserializes pbdat one frame at a time.
module tb_design_1_wrapper;

  logic        clk96M;
  logic        reset;
  logic [14:0] freq;
  logic        bclk;
  logic        pblrc;
  logic        pbdat;

  int n_vec;
  int n_err;

  design_1_wrapper dut (
    .clk96M (clk96M),
    .reset  (reset),
    .freq   (freq),
    .bclk   (bclk),
    .pblrc  (pblrc),
    .pbdat  (pbdat)
  );

  initial clk96M = 1'b0;
  always #5 clk96M = ~clk96M;

  typedef struct {
    logic [14:0] f;
    int          rst_lo;
    int          rst_hi;
    logic [31:0] exp_word;
    logic        exp_at89;
  } vec_t;

  vec_t vecs[18];

  // pos is the frame position presented to the next rising edge.
  // bclk falls at pos%8==4; pblrc is high for pos 4..11, so its fall coincides with a bclk fall.
  task automatic step(input int pos, input logic rst);
    @(negedge clk96M);
    reset = rst;
    bclk  = ((pos % 8) < 4);
    pblrc = (pos >= 4 && pos < 12);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // After step(c), pbdat reflects the edge that saw pos c-1; bit i sits at pos 12+8i..19+8i.
  task automatic run_frame(input vec_t v, output logic [31:0] word, output logic at89, output int tail_ones);
    freq      = v.f;
    word      = '0;
    at89      = 1'b0;
    tail_ones = 0;
    for (int c = 0; c < 1000; c++) begin
      step(c, (c >= v.rst_lo && c < v.rst_hi));
      if (c >= 16 && c <= 264 && ((c - 16) % 8) == 0)
        word[31 - (c - 16) / 8] = pbdat;
      if (c == 89)
        at89 = pbdat;
      if (c >= 270 && pbdat === 1'b1)
        tail_ones++;
    end
  endtask

  initial begin
    logic [31:0] word;
    logic        at89;
    int          tail;

    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    freq  = 15'd440;
    bclk  = 1'b0;
    pblrc = 1'b0;

    vecs[0]  = '{15'd440,   0,  20, 32'h0000_0000, 1'b0};  // power-on reset frame
    vecs[1]  = '{15'd440,  -1,  -1, 32'h004B_004B, 1'b1};
    vecs[2]  = '{15'd440,  -1,  -1, 32'h0096_0096, 1'b0};
    vecs[3]  = '{15'd440,  -1,  -1, 32'h00E1_00E1, 1'b1};
    vecs[4]  = '{15'd600,  -1,  -1, 32'h0147_0147, 1'b1};  // slope change, phase continuous
    vecs[5]  = '{15'd600,  -1,  -1, 32'h01AE_01AE, 1'b0};
    vecs[6]  = '{15'd0,    -1,  -1, 32'h01AE_01AE, 1'b0};  // freq 0 holds phase
    vecs[7]  = '{15'd0,    -1,  -1, 32'h01AE_01AE, 1'b0};
    vecs[8]  = '{15'd440,  -1,  -1, 32'h01F9_01F9, 1'b1};
    vecs[9]  = '{15'd440,   0,  20, 32'h0000_0000, 1'b0};  // full reset, phase back to 0
    vecs[10] = '{15'd440,  88, 108, 32'h0040_0000, 1'b0};  // reset during 10th bit aborts word
    vecs[11] = '{15'd440,  -1,  -1, 32'h004B_004B, 1'b1};
    vecs[12] = '{15'd0,     0,  20, 32'h0000_0000, 1'b0};
    vecs[13] = '{15'd0,    -1,  -1, 32'h0000_0000, 1'b0};  // freq 0 from reset: silent
    vecs[14] = '{15'd0,    -1,  -1, 32'h0000_0000, 1'b0};
    vecs[15] = '{15'd32767, -1, -1, 32'h15D8_15D8, 1'b1};  // max step
    vecs[16] = '{15'd32767, -1, -1, 32'hEBB0_EBB0, 1'b0};  // negative half of sawtooth
    vecs[17] = '{15'd32767, -1, -1, 32'h0188_0188, 1'b0};  // phase wrapped past 2^32

    // Reset state before any frame activity.
    repeat (3) @(negedge clk96M);
    check("reset_pbdat", -1, {31'd0, pbdat}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_frame(vecs[i], word, at89, tail);
      $display("vec %0d freq=%0d word=%h at89=%b tail_ones=%0d", i, vecs[i].f, word, at89, tail);
      check("word", i, word, vecs[i].exp_word);
      check("bit9_next_cycle", i, {31'd0, at89}, {31'd0, vecs[i].exp_at89});
      check("tail_zero", i, tail, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
